// File: rtl/keypad_pkg.sv
// -----------------------------------------------------------------------------
// keypad_pkg
// Shared definitions for the 4x4 matrix keypad. The keypad driver and the
// keypad emulator both use these constants.
//   - key codes KEY_0..KEY_9, KEY_A..KEY_D, KEY_HASH, KEY_STAR, KEY_NONE
//   - one-hot column (COL_x) and row (ROW_x) patterns, bit0 = column/row 1
//   - key_col()/key_row(): map a 4-bit key code to its matrix position
//   - state_e: playback FSM states of the emulator
// -----------------------------------------------------------------------------
package keypad_pkg;

  localparam logic [4:0] KEY_0    = 5'h00;
  localparam logic [4:0] KEY_1    = 5'h01;
  localparam logic [4:0] KEY_2    = 5'h02;
  localparam logic [4:0] KEY_3    = 5'h03;
  localparam logic [4:0] KEY_4    = 5'h04;
  localparam logic [4:0] KEY_5    = 5'h05;
  localparam logic [4:0] KEY_6    = 5'h06;
  localparam logic [4:0] KEY_7    = 5'h07;
  localparam logic [4:0] KEY_8    = 5'h08;
  localparam logic [4:0] KEY_9    = 5'h09;
  localparam logic [4:0] KEY_A    = 5'h0A;
  localparam logic [4:0] KEY_B    = 5'h0B;
  localparam logic [4:0] KEY_C    = 5'h0C;
  localparam logic [4:0] KEY_D    = 5'h0D;
  localparam logic [4:0] KEY_HASH = 5'h0E;
  localparam logic [4:0] KEY_STAR = 5'h0F;
  localparam logic [4:0] KEY_NONE = 5'h10;  // first code that is not a key

  localparam logic [3:0] COL_1 = 4'b0001;
  localparam logic [3:0] COL_2 = 4'b0010;
  localparam logic [3:0] COL_3 = 4'b0100;
  localparam logic [3:0] COL_4 = 4'b1000;

  localparam logic [3:0] ROW_1 = 4'b0001;
  localparam logic [3:0] ROW_2 = 4'b0010;
  localparam logic [3:0] ROW_3 = 4'b0100;
  localparam logic [3:0] ROW_4 = 4'b1000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESS,
    ST_RELEASE
  } state_e;

  // Column that carries the key.
  function automatic logic [3:0] key_col(input logic [3:0] code);
    case (code)
      KEY_1[3:0], KEY_4[3:0], KEY_7[3:0], KEY_STAR[3:0]: key_col = COL_1;
      KEY_2[3:0], KEY_5[3:0], KEY_8[3:0], KEY_0[3:0]:    key_col = COL_2;
      KEY_3[3:0], KEY_6[3:0], KEY_9[3:0], KEY_HASH[3:0]: key_col = COL_3;
      default:                                           key_col = COL_4;  // A, B, C, D
    endcase
  endfunction

  // Row that answers when the key's column is driven.
  function automatic logic [3:0] key_row(input logic [3:0] code);
    case (code)
      KEY_1[3:0], KEY_2[3:0], KEY_3[3:0], KEY_A[3:0]: key_row = ROW_1;
      KEY_4[3:0], KEY_5[3:0], KEY_6[3:0], KEY_B[3:0]: key_row = ROW_2;
      KEY_7[3:0], KEY_8[3:0], KEY_9[3:0], KEY_C[3:0]: key_row = ROW_3;
      default:                                        key_row = ROW_4;  // *, 0, #, D
    endcase
  endfunction

endpackage

// File: rtl/keypad_emulator_if.sv
// -----------------------------------------------------------------------------
// keypad_emulator_if
// Bundles the key stream (key_in/key_valid/key_ready), the matrix side
// (col/fila) and the status outputs (busy/key_err) of the keypad emulator.
//   master : the side that queues keys and scans the matrix
//   slave  : the emulator itself
// -----------------------------------------------------------------------------
interface keypad_emulator_if;

  logic [4:0] key_in;     // key code, 0x00-0x0F are valid
  logic       key_valid;  // key_in is valid this cycle
  logic       key_ready;  // a key can be accepted
  logic [3:0] col;        // one-hot column drive from the scanner
  logic [3:0] fila;       // one-hot row response, 0 when nothing pressed
  logic       busy;       // a key is playing or queued
  logic       key_err;    // invalid code accepted and dropped (1-cycle)

  modport master (
    output key_in, key_valid, col,
    input  key_ready, fila, busy, key_err
  );

  modport slave (
    input  key_in, key_valid, col,
    output key_ready, fila, busy, key_err
  );

endinterface

// File: rtl/key_fifo.sv
// -----------------------------------------------------------------------------
// key_fifo
// Synchronous show-ahead FIFO holding 4-bit key codes.
//   clk, rst        : clock, synchronous active-high reset (flushes the queue)
//   push_i, din_i   : write din_i when push_i and not full
//   pop_i, dout_o   : dout_o is the head entry; pop_i removes it when not empty
//   full_o, empty_o : status flags
// Pointers carry one extra wrap bit so full and empty can be told apart when
// the index bits are equal.
// -----------------------------------------------------------------------------
module key_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push_i,
  input  logic [3:0] din_i,
  input  logic       pop_i,
  output logic [3:0] dout_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic [3:0]  mem_q [DEPTH];
  logic        do_push, do_pop;

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the values from before the clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  // NOTE: the storage array has no reset; the pointers alone decide which
  // entries are meaningful, so clearing the data would only cost logic.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/keypad_emulator.sv
// -----------------------------------------------------------------------------
// keypad_emulator
// Stands in for a physical 4x4 keypad. Queued key codes are played back one at
// a time: each key is "pressed" for PRESS_CYCLES cycles, then released for
// RELEASE_CYCLES cycles, then one IDLE cycle follows.
//   clk : scan clock shared with the keypad driver
//   rst : synchronous active-high reset; drops the current key and the queue
//   kp  : keypad_emulator_if.slave (key stream, col/fila matrix, busy, key_err)
// While a key is pressed, fila returns its row only when col drives exactly its
// column. fila is combinational from col because the scanner samples the rows
// while the column is still applied.
// -----------------------------------------------------------------------------
module keypad_emulator
  import keypad_pkg::*;
#(
  parameter int PRESS_CYCLES   = 8,  // >= 4 so a full column scan sees the key
  parameter int RELEASE_CYCLES = 8,  // >= 1
  parameter int FIFO_DEPTH     = 4   // power of two, >= 2
) (
  input logic               clk,
  input logic               rst,
  keypad_emulator_if.slave  kp
);

  localparam int MAX_CYC = (PRESS_CYCLES > RELEASE_CYCLES) ? PRESS_CYCLES
                                                           : RELEASE_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       cur_key_q, cur_key_d;
  logic             err_q, err_d;
  logic [3:0]       fila;

  logic             accept, code_ok, fifo_push, fifo_pop;
  logic             fifo_full, fifo_empty;
  logic [3:0]       fifo_dout;

  // Codes at or above KEY_NONE are still handshaken but never queued.
  assign accept    = kp.key_valid && kp.key_ready && !rst;
  assign code_ok   = (kp.key_in < KEY_NONE);
  assign fifo_push = accept && code_ok;
  assign err_d     = accept && !code_ok;

  key_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .din_i   (kp.key_in[3:0]),
    .pop_i   (fifo_pop),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      cur_key_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cur_key_q <= cur_key_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can
    // leave it unassigned and no latch is inferred.
    state_d   = state_q;
    cnt_d     = cnt_q;
    cur_key_d = cur_key_q;
    fifo_pop  = 1'b0;
    fila      = 4'b0000;

    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          cur_key_d = fifo_dout;
          cnt_d     = CNT_W'(PRESS_CYCLES - 1);
          state_d   = ST_PRESS;
        end
      end

      ST_PRESS: begin
        // key_col() is one-hot, so equality also rejects a col of 0 or a col
        // with several bits set.
        if (kp.col == key_col(cur_key_q)) fila = key_row(cur_key_q);
        if (cnt_q == '0) begin
          cnt_d   = CNT_W'(RELEASE_CYCLES - 1);
          state_d = ST_RELEASE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      ST_RELEASE: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign kp.fila      = fila;
  assign kp.key_ready = !fifo_full;
  assign kp.busy      = (state_q != ST_IDLE) || !fifo_empty;
  assign kp.key_err   = err_q;

endmodule

// File: tb/tb_keypad_emulator.sv
// -----------------------------------------------------------------------------
// tb_keypad_emulator
// Self-checking bench for keypad_emulator (PRESS=8, RELEASE=8, DEPTH=4).
// Inputs change 1 ns after the rising edge; outputs are read a further 1 ns
// later. A negedge monitor turns row responses back into key codes with its
// own key map and groups them into press windows.
// -----------------------------------------------------------------------------
module tb_keypad_emulator;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  keypad_emulator_if kp ();

  keypad_emulator #(
    .PRESS_CYCLES   (8),
    .RELEASE_CYCLES (8),
    .FIFO_DEPTH     (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .kp  (kp)
  );

  int n_checks = 0;
  int n_pass   = 0;
  bit scan_en  = 1'b0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp)
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    else
      n_pass++;
  endtask

  // Inverse key map, written independently from the design's package.
  function automatic logic [4:0] decode(input logic [3:0] c, input logic [3:0] r);
    case ({c, r})
      8'b0001_0001: return 5'h01;
      8'b0010_0001: return 5'h02;
      8'b0100_0001: return 5'h03;
      8'b1000_0001: return 5'h0A;
      8'b0001_0010: return 5'h04;
      8'b0010_0010: return 5'h05;
      8'b0100_0010: return 5'h06;
      8'b1000_0010: return 5'h0B;
      8'b0001_0100: return 5'h07;
      8'b0010_0100: return 5'h08;
      8'b0100_0100: return 5'h09;
      8'b1000_0100: return 5'h0C;
      8'b0001_1000: return 5'h0F;
      8'b0010_1000: return 5'h00;
      8'b0100_1000: return 5'h0E;
      8'b1000_1000: return 5'h0D;
      default:      return 5'h1F;
    endcase
  endfunction

  // Press-window monitor: hits more than 5 cycles apart start a new press.
  int         mon_cyc  = 0;
  int         last_hit = -100;
  logic [4:0] played [$];
  int         win_len [$];
  int         gaps [$];

  always @(negedge clk) begin
    mon_cyc++;
    if (kp.fila !== 4'b0000) begin
      if (mon_cyc - last_hit > 5) begin
        played.push_back(decode(kp.col, kp.fila));
        win_len.push_back(1);
        gaps.push_back(mon_cyc - last_hit - 1);
      end else begin
        win_len[win_len.size() - 1] = win_len[win_len.size() - 1] + 1;
      end
      last_hit = mon_cyc;
    end
  end

  task automatic clear_mon();
    played.delete();
    win_len.delete();
    gaps.delete();
    last_hit = -100;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (scan_en) kp.col = {kp.col[2:0], kp.col[3]};
  endtask

  task automatic wait_idle(input int max_cycles);
    int n = 0;
    while (kp.busy && n < max_cycles) begin
      tick();
      n++;
    end
    check("wait_idle_timeout", kp.busy, 1'b0);
    repeat (2) tick();
  endtask

  typedef struct {
    logic       key_valid;
    logic [4:0] key_in;
    logic [3:0] col;
    logic [3:0] exp_fila;
    logic       exp_ready;
    logic       exp_busy;
    logic       exp_err;
  } vec_t;

  vec_t vecs [20];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Single key 0x5 pushed at vector 0 (edge t0); vector k is cycle t0+k-1.
    // Column c2 is driven at k = 1, 5, 9, 13, 17; press covers t0+1..t0+8.
    for (int k = 0; k < 20; k++) begin
      int j;
      j = k - 1;
      vecs[k].key_valid = (k == 0);
      vecs[k].key_in    = 5'h05;
      vecs[k].col       = 4'b0001 << (k % 4);
      vecs[k].exp_fila  = (j >= 1 && j <= 8 && vecs[k].col == 4'b0010) ? 4'b0010
                                                                         : 4'b0000;
      vecs[k].exp_ready = 1'b1;
      vecs[k].exp_busy  = (j >= 0 && j <= 16);
      vecs[k].exp_err   = 1'b0;
    end

    rst          = 1'b1;
    kp.key_valid = 1'b0;
    kp.key_in    = 5'h00;
    kp.col       = 4'b0001;
    repeat (3) tick();
    rst = 1'b0;
    #1;
    check("reset_state", {kp.fila, kp.key_ready, kp.busy, kp.key_err}, {4'b0000, 3'b100});

    // ---- single key, table driven -----------------------------------------
    for (int k = 0; k < 20; k++) begin
      kp.key_valid = vecs[k].key_valid;
      kp.key_in    = vecs[k].key_in;
      kp.col       = vecs[k].col;
      #1;
      check($sformatf("single_key_v%0d", k),
            {kp.fila, kp.key_ready, kp.busy, kp.key_err},
            {vecs[k].exp_fila, vecs[k].exp_ready, vecs[k].exp_busy, vecs[k].exp_err});
      tick();
    end
    kp.key_valid = 1'b0;

    // ---- repeat key: two separate presses of 0x1 ---------------------------
    clear_mon();
    kp.col       = 4'b0001;
    kp.key_valid = 1'b1;
    kp.key_in    = 5'h01;
    tick();
    tick();
    kp.key_valid = 1'b0;
    wait_idle(100);
    check("repeat_press_count", played.size(), 2);
    if (played.size() == 2) begin
      check("repeat_key0", played[0], 5'h01);
      check("repeat_key1", played[1], 5'h01);
      check("repeat_win0_len", win_len[0], 8);
      check("repeat_win1_len", win_len[1], 8);
      check("repeat_gap", gaps[1], 9);
    end

    // ---- full queue: six keys back to back while idle ----------------------
    begin
      logic [4:0] keys [6];
      int idx, ticks;
      logic acc;
      keys = '{5'h01, 5'h02, 5'h03, 5'h04, 5'h05, 5'h06};
      clear_mon();
      kp.col       = 4'b0001;
      scan_en      = 1'b1;
      idx          = 0;
      ticks        = 0;
      kp.key_valid = 1'b1;
      kp.key_in    = keys[0];
      while (idx < 6 && ticks < 60) begin
        acc = kp.key_ready;
        tick();
        ticks++;
        if (acc) begin
          idx++;
          if (idx == 5) begin
            check("fifth_accept_tick", ticks, 5);
            check("ready_low_after_5th", kp.key_ready, 1'b0);
          end
          if (idx < 6) kp.key_in = keys[idx];
        end
      end
      kp.key_valid = 1'b0;
      check("sixth_accept_tick", ticks, 20);
      wait_idle(200);
      check("full_press_count", played.size(), 6);
      if (played.size() == 6)
        for (int i = 0; i < 6; i++)
          check($sformatf("full_order_%0d", i), played[i], keys[i]);
    end

    // ---- invalid key 0x13 ---------------------------------------------------
    clear_mon();
    kp.key_valid = 1'b1;
    kp.key_in    = 5'h13;
    #1;
    check("invalid_ready", kp.key_ready, 1'b1);
    tick();
    kp.key_valid = 1'b0;
    #1;
    check("invalid_err_pulse", kp.key_err, 1'b1);
    check("invalid_busy0", kp.busy, 1'b0);
    tick();
    #1;
    check("invalid_err_clear", kp.key_err, 1'b0);
    check("invalid_busy1", kp.busy, 1'b0);
    repeat (20) tick();
    check("invalid_no_press", played.size(), 0);

    // ---- non-one-hot column during press of 0xD ----------------------------
    scan_en      = 1'b0;
    kp.col       = 4'b0000;
    kp.key_valid = 1'b1;
    kp.key_in    = 5'h0D;
    tick();
    kp.key_valid = 1'b0;
    tick();
    kp.col = 4'b0000; #1;
    check("col_zero", kp.fila, 4'b0000);
    kp.col = 4'b1100; #1;
    check("col_multi", kp.fila, 4'b0000);
    kp.col = 4'b0100; #1;
    check("col_wrong", kp.fila, 4'b0000);
    kp.col = 4'b1000; #1;
    check("col_match_d", kp.fila, 4'b1000);
    wait_idle(40);

    // ---- reset in the middle of a press with two keys queued ---------------
    kp.col       = 4'b0010;
    kp.key_valid = 1'b1;
    kp.key_in    = 5'h02;
    tick();
    kp.key_in = 5'h03;
    tick();
    kp.key_in = 5'h04;
    tick();
    kp.key_valid = 1'b0;
    tick();
    #1;
    check("press_before_reset", kp.fila, 4'b0001);
    rst          = 1'b1;
    kp.key_valid = 1'b1;
    kp.key_in    = 5'h07;
    tick();
    rst          = 1'b0;
    kp.key_valid = 1'b0;
    #1;
    check("reset_fila", kp.fila, 4'b0000);
    check("reset_busy", kp.busy, 1'b0);
    check("reset_ready", kp.key_ready, 1'b1);
    clear_mon();
    kp.col  = 4'b0001;
    scan_en = 1'b1;
    repeat (40) tick();
    check("reset_no_press", played.size(), 0);
    check("reset_stays_idle", kp.busy, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
